led_mask_arbiter: RTL and testbench

Shares the board's single 9-LED masked output path between two requesters. Each requester offers a 9-bit switch-style value plus a 9-bit XOR mask over a valid/ready handshake. The block grants one requester at a time (round-robin), drives `o_led = data ^ mask`, and holds that pattern for a programmable number of clocks before accepting the next request. It sits between the switch/debug sources and the LED pins, replacing a fixed-mask combinational XOR.

---
 rtl/led_mask_arbiter.sv | 98 +++++++++
 tb/tb_led_mask_arbiter.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_mask_arbiter.sv
// led_mask_arbiter: round-robin arbiter that lets one of two requesters own the
// 9-LED output path. The granted data ^ mask pattern is registered onto the LEDs
// and held for HOLD_CYCLES clocks before the next request is accepted.
module led_mask_arbiter #(
    parameter int unsigned HOLD_CYCLES = 1000   // legal range 1 .. 2^20-1
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_a_valid,
    output logic       o_a_ready,
    input  logic [8:0] i_a_data,
    input  logic [8:0] i_a_mask,
    input  logic       i_b_valid,
    output logic       o_b_ready,
    input  logic [8:0] i_b_data,
    input  logic [8:0] i_b_mask,
    output logic [8:0] o_led,
    output logic       o_busy,
    output logic       o_owner
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    // Counter reload: the transfer edge itself is the first held clock.
    localparam logic [19:0] HOLD_LOAD = 20'(HOLD_CYCLES - 1);

    state_t      r_state;
    logic [19:0] r_count;
    logic        r_prio;    // 0 = A wins a tie, 1 = B wins a tie
    logic [8:0]  r_led;
    logic        r_owner;
    logic        r_busy;

    logic        w_idle;
    logic        w_a_ready;
    logic        w_b_ready;

    // Grant decode: depends only on state, valids and the priority pointer, never
    // on data or mask. Reset forces both readys low so nothing is granted while
    // the block is held in reset.
    assign w_idle    = (r_state == ST_IDLE) && !i_reset;
    assign w_a_ready = w_idle && i_a_valid && (!i_b_valid || !r_prio);
    assign w_b_ready = w_idle && i_b_valid && (!i_a_valid ||  r_prio);

    // Arbitration FSM: capture the winning pattern, then count out the hold time.
    // NOTE: every register here uses <= so all state updates see the values from
    // before this edge; a blocking = would let later lines read already-updated
    // state and silently reorder the hardware.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
            r_count <= '0;
            r_prio  <= 1'b0;
            r_led   <= 9'h000;
            r_owner <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_a_ready) begin
                        r_led   <= i_a_data ^ i_a_mask;
                        r_owner <= 1'b0;
                        r_prio  <= 1'b1;
                        r_busy  <= 1'b1;
                        r_count <= HOLD_LOAD;
                        r_state <= ST_HOLD;
                    end else if (w_b_ready) begin
                        r_led   <= i_b_data ^ i_b_mask;
                        r_owner <= 1'b1;
                        r_prio  <= 1'b0;
                        r_busy  <= 1'b1;
                        r_count <= HOLD_LOAD;
                        r_state <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    // LEDs and owner keep their value on the way back to IDLE.
                    if (r_count == 20'd0) begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_count <= r_count - 20'd1;
                    end
                end
            endcase
        end
    end

    assign o_a_ready = w_a_ready;
    assign o_b_ready = w_b_ready;
    assign o_led     = r_led;
    assign o_busy    = r_busy;
    assign o_owner   = r_owner;

endmodule

// File: tb/tb_led_mask_arbiter.sv
// Directed bench for led_mask_arbiter. dut_h4 (HOLD_CYCLES=4) covers handshake,
// hold length, round-robin, pointer persistence and async reset; dut_h1
// (HOLD_CYCLES=1) covers the minimum hold with changing data.
module tb_led_mask_arbiter;

    logic       clk;
    logic       rst;

    // dut_h4 stimulus / observation
    logic       a_valid, b_valid;
    logic [8:0] a_data, a_mask, b_data, b_mask;
    logic       a_ready, b_ready;
    logic [8:0] led;
    logic       busy, owner;

    // dut_h1 stimulus / observation
    logic       c_a_valid, c_b_valid;
    logic [8:0] c_a_data, c_a_mask, c_b_data, c_b_mask;
    logic       c_a_ready, c_b_ready;
    logic [8:0] c_led;
    logic       c_busy, c_owner;

    int n_checks = 0;
    int n_errors = 0;

    led_mask_arbiter #(.HOLD_CYCLES(4)) dut_h4 (
        .i_clk     (clk),
        .i_reset   (rst),
        .i_a_valid (a_valid),
        .o_a_ready (a_ready),
        .i_a_data  (a_data),
        .i_a_mask  (a_mask),
        .i_b_valid (b_valid),
        .o_b_ready (b_ready),
        .i_b_data  (b_data),
        .i_b_mask  (b_mask),
        .o_led     (led),
        .o_busy    (busy),
        .o_owner   (owner)
    );

    led_mask_arbiter #(.HOLD_CYCLES(1)) dut_h1 (
        .i_clk     (clk),
        .i_reset   (rst),
        .i_a_valid (c_a_valid),
        .o_a_ready (c_a_ready),
        .i_a_data  (c_a_data),
        .i_a_mask  (c_a_mask),
        .i_b_valid (c_b_valid),
        .o_b_ready (c_b_ready),
        .i_b_data  (c_b_data),
        .i_b_mask  (c_b_mask),
        .o_led     (c_led),
        .o_busy    (c_busy),
        .o_owner   (c_owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Wait (bounded) until dut_h4 leaves HOLD; samples at negedge+1.
    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("idle_timeout", {31'd0, busy}, 32'd0);
    endtask

    logic [8:0] tbl [0:8];
    logic       exp_owner;
    logic       pend;
    int         grants;
    int         last_cyc;
    int         n_busy;

    initial begin
        tbl[0] = 9'h001; tbl[1] = 9'h0F0; tbl[2] = 9'h155;
        tbl[3] = 9'h1FF; tbl[4] = 9'h02A; tbl[5] = 9'h100;
        tbl[6] = 9'h0C3; tbl[7] = 9'h03C; tbl[8] = 9'h0AA;

        rst = 1'b1;
        a_valid = 1'b1; b_valid = 1'b1;
        a_data = 9'h000; a_mask = 9'h087;
        b_data = 9'h000; b_mask = 9'h000;
        c_a_valid = 1'b0; c_b_valid = 1'b0;
        c_a_data = 9'h000; c_a_mask = 9'h10F;
        c_b_data = 9'h000; c_b_mask = 9'h000;

        // Reset state, with valids asserted to show readys stay low.
        #2;
        check("rst_led",   {23'd0, led},   32'h000);
        check("rst_busy",  {31'd0, busy},  32'd0);
        check("rst_owner", {31'd0, owner}, 32'd0);
        check("rst_a_rdy", {31'd0, a_ready}, 32'd0);
        check("rst_b_rdy", {31'd0, b_ready}, 32'd0);

        // Basic A transfer: data 000 ^ mask 087.
        @(negedge clk);
        rst = 1'b0;
        b_valid = 1'b0;
        #1;
        check("a_rdy",    {31'd0, a_ready}, 32'd1);
        check("a_b_rdy",  {31'd0, b_ready}, 32'd0);
        @(negedge clk);
        a_valid = 1'b0;
        #1;
        check("a_led",   {23'd0, led},   32'h087);
        check("a_owner", {31'd0, owner}, 32'd0);
        check("a_busy",  {31'd0, busy},  32'd1);
        wait_idle();

        // B transfer: 1FF ^ 087 = 178; hold exactly 4 cycles.
        @(negedge clk);
        b_valid = 1'b1; b_data = 9'h1FF; b_mask = 9'h087;
        #1;
        check("b_rdy", {31'd0, b_ready}, 32'd1);
        @(negedge clk);
        #1;
        check("b_owner", {31'd0, owner}, 32'd1);
        n_busy = 0;
        while (busy && n_busy < 20) begin
            check("b_hold_rdy", {31'd0, b_ready}, 32'd0);
            check("b_hold_led", {23'd0, led}, 32'h178);
            n_busy++;
            @(negedge clk);
            #1;
        end
        b_valid = 1'b0;
        check("b_busy_len", n_busy, 32'd4);
        check("b_led_kept", {23'd0, led}, 32'h178);
        check("b_owner_kept", {31'd0, owner}, 32'd1);

        // Round-robin: both valid, six grants A,B,A,B,A,B spaced 5 clocks.
        a_data = 9'h055; a_mask = 9'h000;
        b_data = 9'h0AA; b_mask = 9'h000;
        grants = 0; last_cyc = 0; pend = 1'b0; exp_owner = 1'b0;
        for (int cyc = 0; cyc < 80 && (grants < 6 || pend); cyc++) begin
            @(negedge clk);
            a_valid = 1'b1; b_valid = 1'b1;
            #1;
            if (pend) begin
                check("rr_owner", {31'd0, owner}, {31'd0, exp_owner});
                check("rr_busy",  {31'd0, busy},  32'd1);
                pend = 1'b0;
            end
            if (busy) begin
                check("rr_hold_rdy", {30'd0, a_ready, b_ready}, 32'd0);
            end else if (grants < 6) begin
                check("rr_seq", {30'd0, a_ready, b_ready}, (grants % 2 == 0) ? 32'd2 : 32'd1);
                if (grants > 0) check("rr_gap", cyc - last_cyc, 32'd5);
                exp_owner = b_ready;
                last_cyc = cyc;
                grants++;
                pend = 1'b1;
            end
        end
        check("rr_grants", grants, 32'd6);
        a_valid = 1'b0; b_valid = 1'b0;
        wait_idle();

        // Pointer persistence: A, A again (alone), then both -> B.
        @(negedge clk);
        a_valid = 1'b1;
        #1;
        check("pp_a1_rdy", {31'd0, a_ready}, 32'd1);
        @(negedge clk);
        a_valid = 1'b0;
        #1;
        check("pp_a1_owner", {31'd0, owner}, 32'd0);
        wait_idle();
        @(negedge clk);
        a_valid = 1'b1;
        #1;
        check("pp_a2_rdy", {31'd0, a_ready}, 32'd1);
        @(negedge clk);
        a_valid = 1'b0;
        #1;
        check("pp_a2_owner", {31'd0, owner}, 32'd0);
        wait_idle();
        @(negedge clk);
        a_valid = 1'b1; b_valid = 1'b1;
        #1;
        check("pp_both_rdy", {30'd0, a_ready, b_ready}, 32'd1);
        @(negedge clk);
        a_valid = 1'b0; b_valid = 1'b0;
        #1;
        check("pp_b_owner", {31'd0, owner}, 32'd1);
        check("pp_b_led",   {23'd0, led},   32'h0AA);
        wait_idle();

        // Reset mid-HOLD after an A grant (pointer then favours B).
        @(negedge clk);
        a_valid = 1'b1; a_data = 9'h1A5; a_mask = 9'h000;
        @(negedge clk);
        a_valid = 1'b0;
        #1;
        check("mr_led_pre",  {23'd0, led},  32'h1A5);
        check("mr_busy_pre", {31'd0, busy}, 32'd1);
        #2;
        a_valid = 1'b1; a_data = 9'h0F0; a_mask = 9'h00F;
        b_valid = 1'b1; b_data = 9'h100; b_mask = 9'h001;
        rst = 1'b1;
        #1;
        check("mr_led",   {23'd0, led},   32'h000);
        check("mr_busy",  {31'd0, busy},  32'd0);
        check("mr_owner", {31'd0, owner}, 32'd0);
        check("mr_rdy",   {30'd0, a_ready, b_ready}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("mr_first_rdy", {30'd0, a_ready, b_ready}, 32'd2);
        @(negedge clk);
        a_valid = 1'b0; b_valid = 1'b0;
        #1;
        check("mr_owner_post", {31'd0, owner}, 32'd0);
        check("mr_led_post",   {23'd0, led},   32'h0FF);
        check("mr_busy_post",  {31'd0, busy},  32'd1);
        wait_idle();

        // HOLD_CYCLES=1: transfer every 2 clocks, data changes while ready low.
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            c_a_valid = 1'b1;
            c_a_data  = tbl[k];
            #1;
            if (k % 2 == 0) begin
                check("h1_rdy_even",  {31'd0, c_a_ready}, 32'd1);
                check("h1_busy_even", {31'd0, c_busy},    32'd0);
                if (k > 0) check("h1_led_kept", {23'd0, c_led}, {23'd0, tbl[k-2] ^ 9'h10F});
            end else begin
                check("h1_rdy_odd",  {31'd0, c_a_ready}, 32'd0);
                check("h1_busy_odd", {31'd0, c_busy},    32'd1);
                check("h1_led",      {23'd0, c_led},     {23'd0, tbl[k-1] ^ 9'h10F});
                check("h1_owner",    {31'd0, c_owner},   32'd0);
            end
        end
        c_a_valid = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
